// File: rtl/entity_table_if.sv
// entity_table_if: spawn/delete handshake between requesters and an entity table.
interface entity_table_if #(parameter int ADDR_W = 10, parameter int ENTITY_SIZE = 34);
   logic                   delete_req;
   logic [ADDR_W-1:0]      delete_address;
   logic                   spawn_valid;
   logic [ENTITY_SIZE-1:0] spawn_entity;
   logic                   spawn_ready;
   logic                   spawn_done;
   logic [ADDR_W-1:0]      spawn_slot;
   logic                   spawn_fail;
   logic                   delete_ack;
   logic                   bad_delete;
   modport master(output delete_req, delete_address, spawn_valid, spawn_entity,
                  input spawn_ready, spawn_done, spawn_slot, spawn_fail, delete_ack, bad_delete);
   modport slave(input delete_req, delete_address, spawn_valid, spawn_entity,
                 output spawn_ready, spawn_done, spawn_slot, spawn_fail, delete_ack, bad_delete);
endinterface

// File: rtl/entity_table.sv
// entity_table: slot table of game entities with sequential-scan spawn allocation
// and independent single-cycle deletes.
module entity_table #(
   parameter int MAX_ENTRIES = 3,
   parameter int ENTITY_SIZE = 34,
   parameter int ADDR_W = 10,
   localparam int CW = $clog2(MAX_ENTRIES + 1),
   localparam int IW = MAX_ENTRIES > 1 ? $clog2(MAX_ENTRIES) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   entity_table_if.slave                          bus,
   output logic [MAX_ENTRIES-1:0][ENTITY_SIZE-1:0] entities,
   output logic [CW-1:0]                          active_count
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t                 state;
   logic [ADDR_W-1:0]      idx;
   logic [ENTITY_SIZE-1:0] rec;
   logic                   write, del_ok, dec;
   logic [IW-1:0]          ii, da;

   always_comb begin
      ii = idx[IW-1:0];
      da = bus.delete_address[IW-1:0];
      write = state == SCAN && !entities[ii][ENTITY_SIZE-1];
      del_ok = bus.delete_req && bus.delete_address < ADDR_W'(MAX_ENTRIES);
      dec = del_ok && entities[da][ENTITY_SIZE-1];
   end

   // the spawn write is issued after the delete so it wins on a same-slot collision
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entities <= '0;
         active_count <= '0;
         state <= IDLE;
         idx <= '0;
         rec <= '0;
         bus.spawn_ready <= 1'b1;
         bus.spawn_done <= 1'b0;
         bus.spawn_slot <= '0;
         bus.spawn_fail <= 1'b0;
         bus.delete_ack <= 1'b0;
         bus.bad_delete <= 1'b0;
      end else begin
         bus.spawn_done <= 1'b0;
         bus.spawn_fail <= 1'b0;
         bus.delete_ack <= del_ok;
         bus.bad_delete <= bus.delete_req && !del_ok;
         active_count <= active_count + CW'(write) - CW'(dec);
         if (del_ok) entities[da] <= '0;
         if (state == IDLE) begin
            if (bus.spawn_valid && bus.spawn_ready) begin
               rec <= bus.spawn_entity;
               idx <= '0;
               state <= SCAN;
               bus.spawn_ready <= 1'b0;
            end
         end else if (write) begin
            entities[ii] <= {1'b1, rec[ENTITY_SIZE-2:0]};
            bus.spawn_slot <= idx;
            bus.spawn_done <= 1'b1;
            bus.spawn_ready <= 1'b1;
            state <= IDLE;
         end else if (idx == ADDR_W'(MAX_ENTRIES - 1)) begin
            bus.spawn_fail <= 1'b1;
            bus.spawn_ready <= 1'b1;
            state <= IDLE;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end
endmodule
